// File: rtl/status_register.sv
// status_register
//   Condition-flag producer at the end of the execute stage. Computes N, Z, C, V
//   for flag-setting ALU instructions, holds them in a live register, and keeps
//   a one-entry saved copy for exception entry/return.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   exe_cmd      ALU command (MOV/MVN/ADD/ADC/SUB/SBC/AND/ORR/EOR, others no effect)
//   op1, op2     first operand (Rn) and shifter output
//   s_en         S bit set and instruction valid in execute
//   cond_pass    instruction condition evaluated true
//   freeze       pipeline stall, holds all state
//   save_en      copy live flags into the saved copy
//   restore_en   copy saved flags into the live flags
//   status       live flags {z, c, n, v}, registered
//   saved_status saved flags {z, c, n, v}, registered
//   update_done  one-cycle pulse after a qualified flag-setting write
module status_register #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       exe_cmd,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  input  logic             s_en,
  input  logic             cond_pass,
  input  logic             freeze,
  input  logic             save_en,
  input  logic             restore_en,
  output logic [3:0]       status,
  output logic [3:0]       saved_status,
  output logic             update_done
);

  localparam int MSB = WIDTH - 1;

  typedef enum logic [3:0] {
    CMD_MOV = 4'b0001,
    CMD_ADD = 4'b0010,
    CMD_ADC = 4'b0011,
    CMD_SUB = 4'b0100,
    CMD_SBC = 4'b0101,
    CMD_AND = 4'b0110,
    CMD_ORR = 4'b0111,
    CMD_EOR = 4'b1000,
    CMD_MVN = 4'b1001
  } alu_cmd_e;

  // Flag positions inside the packed {z, c, n, v} word.
  localparam int FZ = 3;
  localparam int FC = 2;
  localparam int FN = 1;
  localparam int FV = 0;

  logic             cin;
  logic             upd;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] res;
  logic             flag_z;
  logic             flag_c;
  logic             flag_n;
  logic             flag_v;
  logic             cmd_known;
  logic [3:0]       new_flags;

  // Carry-in always comes from the registered live C, never forwarded.
  assign cin = status[FC];
  assign upd = s_en & cond_pass & ~freeze;

  // Result and arithmetic flags. Subtraction is done as op1 + ~op2 + carry so
  // that bit WIDTH of the sum is directly the NOT-borrow carry flag.
  always_comb begin
    sum       = '0;
    res       = '0;
    flag_c    = status[FC];
    flag_v    = status[FV];
    cmd_known = 1'b1;
    unique case (exe_cmd)
      CMD_MOV: res = op2;
      CMD_MVN: res = ~op2;
      CMD_AND: res = op1 & op2;
      CMD_ORR: res = op1 | op2;
      CMD_EOR: res = op1 ^ op2;
      CMD_ADD, CMD_ADC: begin
        sum    = {1'b0, op1} + {1'b0, op2}
               + ((exe_cmd == CMD_ADC) ? (WIDTH+1)'(cin) : '0);
        res    = sum[MSB:0];
        flag_c = sum[WIDTH];
        flag_v = (op1[MSB] == op2[MSB]) && (sum[MSB] != op1[MSB]);
      end
      CMD_SUB, CMD_SBC: begin
        sum    = {1'b0, op1} + {1'b0, ~op2}
               + ((exe_cmd == CMD_SUB) ? (WIDTH+1)'(1) : (WIDTH+1)'(cin));
        res    = sum[MSB:0];
        flag_c = sum[WIDTH];
        flag_v = (op1[MSB] != op2[MSB]) && (sum[MSB] != op1[MSB]);
      end
      default: cmd_known = 1'b0;
    endcase
  end

  assign flag_n = res[MSB];
  assign flag_z = (res == '0);

  // Unlisted commands leave every flag untouched.
  always_comb begin
    new_flags = status;
    if (cmd_known) begin
      new_flags[FZ] = flag_z;
      new_flags[FC] = flag_c;
      new_flags[FN] = flag_n;
      new_flags[FV] = flag_v;
    end
  end

  // Live flags: restore outranks a simultaneous update.
  always_ff @(posedge clk) begin
    if (rst) begin
      status      <= '0;
      update_done <= 1'b0;
    end else if (freeze) begin
      update_done <= 1'b0;
    end else if (restore_en) begin
      status      <= saved_status;
      update_done <= 1'b0;
    end else if (upd) begin
      status      <= new_flags;
      update_done <= 1'b1;
    end else begin
      update_done <= 1'b0;
    end
  end

  // Saved copy captures the pre-edge live value, so save+restore swaps.
  always_ff @(posedge clk) begin
    if (rst) begin
      saved_status <= '0;
    end else if (!freeze && save_en) begin
      saved_status <= status;
    end
  end

endmodule

// File: doc/status_register.md
# status_register

Producer of the architectural condition flags consumed by the condition-check stage. It sits at the end of the execute stage:
- computes N, Z, C, V from the ALU command and operands of a flag-setting instruction;
- holds them in a 4-bit register, plus a one-entry saved copy for exception entry and return;
- presents them packed as `{z, c, n, v}` to the next instruction's condition evaluation.

## Interface

Parameters:
- `WIDTH`, 32, operand width; flags derive from bit `WIDTH-1` and the `WIDTH`-bit result.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `exe_cmd`  in  4  ALU command:
  - 0001 MOV, 1001 MVN, 0010 ADD, 0011 ADC, 0100 SUB, 0101 SBC, 0110 AND, 0111 ORR, 1000 EOR.
  - Any other code is "no flag effect".
- `op1`  in  WIDTH  first operand (Rn).
- `op2`  in  WIDTH  second operand (shifter output).
- `s_en`  in  1  instruction has S bit set and is valid in execute.
- `cond_pass`  in  1  instruction's condition evaluated true.
- `freeze`  in  1  pipeline stall; holds all state.
- `save_en`  in  1  exception entry: copy live flags to saved copy.
- `restore_en`  in  1  exception return: copy saved flags to live flags.
- `status`  out  4  live flags `{z, c, n, v}`, registered.
- `saved_status`  out  4  saved flags `{z, c, n, v}`, registered.
- `update_done`  out  1  registered pulse: live flags were written by a flag-setting instruction on the previous edge.

## Operation

Result computation (combinational, `WIDTH+1` bits internally; `cin` = current live C):
- MOV: `op2`. MVN: `~op2`.
- ADD: `op1 + op2`. ADC: `op1 + op2 + cin`.
- SUB: `op1 - op2`. SBC: `op1 - op2 - !cin`.
- AND, ORR, EOR: bitwise.

Flag rules:
- N = `res[WIDTH-1]`. Z = (`res[WIDTH-1:0]` == 0).
- ADD/ADC:
  - C = carry out of bit `WIDTH-1`, i.e. bit `WIDTH` of the `WIDTH+1`-bit sum.
  - V = (`op1[msb]` == `op2[msb]`) && (`res[msb]` != `op1[msb]`).
- SUB/SBC:
  - C = NOT borrow; for SUB, C = 1 iff `op1 >= op2` unsigned.
  - V = (`op1[msb]` != `op2[msb]`) && (`res[msb]` != `op1[msb]`).
- MOV, MVN, AND, ORR, EOR: N and Z updated; C and V keep their current values.
- Unlisted `exe_cmd`: no flag change even when `upd` is high. `update_done` still pulses.

Update qualifier: `upd = s_en & cond_pass & !freeze`.

Priority at each rising edge (first matching rule applies to the live flags):
1. `rst`: `status` = 0000, `saved_status` = 0000, `update_done` = 0.
2. `freeze`: all registers hold, `update_done` = 0. Save, restore and update are all ignored.
3. `restore_en`: `status` <= `saved_status`, `update_done` = 0. Any simultaneous `upd` is discarded.
4. `upd`: `status` <= new flags, `update_done` = 1.
5. Otherwise: hold, `update_done` = 0.

Saved copy:
- `save_en` (not frozen, not reset) sets `saved_status` <= current `status`, i.e. the pre-update value, even when `upd` is high on the same edge.
- `save_en` together with `restore_en`: both swap through the old values. Live gets the old saved copy; saved gets the old live flags.

## Timing

- Flag latency: operands presented in cycle t with `upd` high; new `status` is visible after the edge ending cycle t. The condition check for the instruction in execute at t+1 sees it.
- No combinational path from any input to `status`, `saved_status` or `update_done`.
- `cin` is always the registered live C, never a same-cycle forwarded value.
- Reset mid-sequence clears everything on the same edge, regardless of `freeze`.
- All outputs read 0 from the first edge with `rst` high until the first qualified update after reset is released.

## Test plan

- Reset, then ADD `op1` = 0xFFFFFFFF, `op2` = 0x00000001, `s_en` = 1, `cond_pass` = 1 -> `status` = 1100 (Z=1, C=1, N=0, V=0), `update_done` = 1 for one cycle.
- ADD 0x7FFFFFFF + 1 -> `status` = 0011 (N=1, V=1). Then SUB 5 - 7 -> `status` = 0010 (C=0 borrow, N=1, V=0).
- From C=1: ADC 1 + 1 -> result 3, C=0. From C=0: SBC 5 - 2 -> result 2, C=1.
- From `status` = 0101, AND 0xF0 & 0x0F -> `status` = 1101 (Z=1; C and V retained). Same op with `cond_pass` = 0 or `s_en` = 0 -> `status` stays 0101.
- `freeze` = 1 with `upd` inputs, `save_en` and `restore_en` all high -> no register changes, `update_done` = 0.
- Save/restore sequence:
  - `status` = 0100: pulse `save_en` with a SUB 3 - 3 on the same edge -> `saved_status` = 0100, `status` = 1100.
  - `restore_en` with ADD 0x7FFFFFFF + 1 on the same edge -> `status` = 0100, `update_done` = 0.
  - Assert `rst` mid-sequence -> both registers read 0000 after the edge.
